// File: rtl/fwuart_pkg.sv
// Shared types and constants for the fwuart serial link.
// Receive FSM states and oversampling points.
package fwuart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_e;

    localparam int         OVERSAMPLE = 16;
    localparam logic [3:0] MID_START  = 4'd7;
    localparam logic [3:0] MID_BIT    = 4'd15;
    localparam int         DATA_BITS  = 8;

    // Returns 1 when the received parity bit disagrees with the data.
    function automatic logic parity_bad(
        input logic [DATA_BITS-1:0] bits,
        input logic                 pbit,
        input logic                 odd
    );
        return (^bits ^ pbit) != odd;
    endfunction

endpackage

// File: rtl/fwuart_sync.sv
// Multi-flop synchronizer for the asynchronous rx line.
// Resets to 1 so an idle line is never seen as a start bit.
module fwuart_sync
    import fwuart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] ff;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ff <= '1;
        end else begin
            ff <= {ff[SYNC_STAGES-2:0], d};
        end
    end

    assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/fwuart_rx.sv
// UART receiver: 16x oversampled 8N1 frames into a 1-entry valid/ready hold register.
// Define FWUART_RX_PARITY_EN for 8E1/8O1 frames with a parity_err output.
module fwuart_rx
    import fwuart_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter bit PARITY_ODD  = 1'b0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       clock_x16,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       frame_err,
    output logic       overrun
`ifdef FWUART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    rx_state_e      state;
    rx_state_e      next_state;
    logic           rx_s;
    logic [3:0]     tick_cnt;
    logic [2:0]     bit_cnt;
    logic [7:0]     shift;
    logic           mid_bit;
    logic           last_bit;
    logic           deliver;
    logic           frame_bad;

    fwuart_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clock(clock),
        .reset(reset),
        .d    (rx),
        .q    (rx_s)
    );

    assign mid_bit  = clock_x16 && (tick_cnt == MID_BIT);
    assign last_bit = (bit_cnt == 3'(DATA_BITS - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (clock_x16) begin
            unique case (state)
                IDLE: begin
                    if (!rx_s) next_state = START;
                end
                START: begin
                    if (tick_cnt == MID_START)
                        next_state = rx_s ? IDLE : DATA;
                end
                DATA: begin
                    if (tick_cnt == MID_BIT && last_bit)
`ifdef FWUART_RX_PARITY_EN
                        next_state = PARITY;
`else
                        next_state = STOP;
`endif
                end
                PARITY: begin
                    if (tick_cnt == MID_BIT) next_state = STOP;
                end
                STOP: begin
                    if (tick_cnt == MID_BIT)
                        next_state = rx_s ? IDLE : BREAK;
                end
                BREAK: begin
                    if (rx_s) next_state = IDLE;
                end
                default: next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        deliver   = 1'b0;
        frame_bad = 1'b0;
        if (state == STOP && mid_bit) begin
            deliver   = rx_s;
            frame_bad = !rx_s;
        end
    end

    // Counters restart on entry to START/DATA; DATA onward lets tick_cnt wrap.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
        end else if (clock_x16) begin
            if (state != next_state &&
                (next_state == START || next_state == DATA)) begin
                tick_cnt <= '0;
            end else if (state == IDLE || state == BREAK) begin
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick_cnt + 4'd1;
            end
            if (state == START && next_state == DATA) begin
                bit_cnt <= '0;
            end else if (state == DATA && tick_cnt == MID_BIT) begin
                shift[bit_cnt] <= rx_s;
                bit_cnt        <= bit_cnt + 3'd1;
            end
        end
    end

`ifdef FWUART_RX_PARITY_EN
    logic par_bad;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            par_bad <= 1'b0;
        end else if (state == PARITY && mid_bit) begin
            par_bad <= parity_bad(shift, rx_s, PARITY_ODD);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= deliver && par_bad;
        end
    end
`endif

    // Hold register: a same-cycle accept frees the slot for the new byte.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data       <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err <= frame_bad;
            overrun   <= 1'b0;
            if (deliver) begin
                if (!data_valid || data_ready) begin
                    data       <= shift;
                    data_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule
